// File: rtl/alu_seg_display.sv
// Seven-segment output stage for the 4-bit ALU: snapshots the operands, selects, result and carry,
// then scans them across an 8-digit common-anode display with an optional freeze (hold).
module alu_seg_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    input  logic       mode,
    input  logic [3:0] result,
    input  logic       c_out,
    input  logic       hold,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic       mode;
        logic [3:0] result;
        logic       c_out;
    } snap_t;

    // A one-bit counter is kept for REFRESH_DIV=1 so the wrap compare stays legal; it then wraps every edge.
    localparam int              CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    snap_t            snap;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic             wrap;

    logic [3:0]       nibble;
    logic             blank;
    logic [7:0]       next_an;
    logic [6:0]       next_seg;
    logic             next_dp;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0:    hex_seg = 7'b1000000;
            4'h1:    hex_seg = 7'b1111001;
            4'h2:    hex_seg = 7'b0100100;
            4'h3:    hex_seg = 7'b0110000;
            4'h4:    hex_seg = 7'b0011001;
            4'h5:    hex_seg = 7'b0010010;
            4'h6:    hex_seg = 7'b0000010;
            4'h7:    hex_seg = 7'b1111000;
            4'h8:    hex_seg = 7'b0000000;
            4'h9:    hex_seg = 7'b0010000;
            4'hA:    hex_seg = 7'b0001000;
            4'hB:    hex_seg = 7'b0000011;
            4'hC:    hex_seg = 7'b1000110;
            4'hD:    hex_seg = 7'b0100001;
            4'hE:    hex_seg = 7'b0000110;
            default: hex_seg = 7'b0001110;
        endcase
    endfunction

    assign wrap = (cnt == CNT_MAX);

    // NOTE: every output of this block gets a default first, so no path through the case can infer a latch.
    always_comb begin
        nibble = 4'h0;
        blank  = 1'b0;
        case (idx)
            3'd0:    nibble = snap.result;
            3'd1:    nibble = {3'b000, snap.c_out};
            3'd3:    nibble = {1'b0, snap.op};
            3'd4:    nibble = {3'b000, snap.mode};
            3'd6:    nibble = snap.b;
            3'd7:    nibble = snap.a;
            default: blank  = 1'b1;
        endcase
        next_an  = blank ? 8'hFF : ~(8'h01 << idx);
        next_seg = blank ? 7'h7F : hex_seg(nibble);
        next_dp  = ~((idx == 3'd0) & hold);
    end

    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap <= '0;
            cnt  <= '0;
            idx  <= 3'd0;
            an   <= 8'hFF;
            seg  <= 7'h7F;
            dp   <= 1'b1;
        end else begin
            if (!hold) begin
                snap <= '{a: a, b: b, op: op, mode: mode, result: result, c_out: c_out};
            end
            if (wrap) begin
                cnt <= '0;
                idx <= idx + 3'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            an  <= next_an;
            seg <= next_seg;
            dp  <= next_dp;
        end
    end

endmodule

// File: tb/tb_alu_seg_display.sv
// Bench for alu_seg_display: two instances (REFRESH_DIV 4 and 1) checked every cycle against an
// arithmetic scan model, plus literal scan/segment expectations from hand-worked scenarios.
module tb_alu_seg_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a = 4'h0, b = 4'h0, result = 4'h0;
    logic [2:0] op = 3'd0;
    logic       mode = 1'b0, c_out = 1'b0, hold = 1'b0;

    logic [7:0] an4, an1;
    logic [6:0] seg4, seg1;
    logic       dp4, dp1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seg_display #(.REFRESH_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .mode(mode), .result(result),
        .c_out(c_out), .hold(hold), .an(an4), .seg(seg4), .dp(dp4)
    );

    alu_seg_display #(.REFRESH_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .mode(mode), .result(result),
        .c_out(c_out), .hold(hold), .an(an1), .seg(seg1), .dp(dp1)
    );

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model snapshot and the number of non-reset edges since the last reset.
    int   ticks = 0;
    int   m_a = 0, m_b = 0, m_op = 0, m_mode = 0, m_result = 0, m_c_out = 0;
    logic [15:0] e4, e1;

    // {an, seg, dp} shown after an edge where the scan position was idx.
    function automatic logic [15:0] expect_out(input int idx, input logic h);
        int val;
        bit blank;
        val   = 0;
        blank = 1'b0;
        case (idx)
            0:       val = m_result;
            1:       val = m_c_out;
            3:       val = m_op;
            4:       val = m_mode;
            6:       val = m_b;
            7:       val = m_a;
            default: blank = 1'b1;
        endcase
        if (blank) return {8'hFF, 7'h7F, 1'b1};
        return {~(8'h01 << idx), hex_tab[val], (idx == 0 && h) ? 1'b0 : 1'b1};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                e4 = {8'hFF, 7'h7F, 1'b1};
                e1 = e4;
                ticks = 0;
                m_a = 0; m_b = 0; m_op = 0; m_mode = 0; m_result = 0; m_c_out = 0;
            end else begin
                e4 = expect_out((ticks / 4) % 8, hold);
                e1 = expect_out(ticks % 8, hold);
                if (!hold) begin
                    m_a = a; m_b = b; m_op = op; m_mode = mode; m_result = result; m_c_out = c_out;
                end
                ticks++;
            end
            #1;
            check("model_an4",  an4,          e4[15:8]);
            check("model_seg4", {1'b0, seg4}, {1'b0, e4[7:1]});
            check("model_dp4",  {7'd0, dp4},  {7'd0, e4[0]});
            check("model_an1",  an1,          e1[15:8]);
            check("model_seg1", {1'b0, seg1}, {1'b0, e1[7:1]});
            check("model_dp1",  {7'd0, dp1},  {7'd0, e1[0]});
        end
    end

    logic [7:0] an_seq [8] = '{8'hFE, 8'hFD, 8'hFF, 8'hF7, 8'hEF, 8'hFF, 8'hBF, 8'h7F};
    // Segment pattern per scan position for a=A b=3 op=2 mode=1 result=D c_out=0.
    logic [6:0] dig_tab [8] = '{7'b0100001, 7'b1000000, 7'h7F, 7'b0100100,
                                7'b1111001, 7'h7F, 7'b0110000, 7'b0001000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] prev;
        bit found;

        repeat (3) tick();
        check("rst_an",  an4,          8'hFF);
        check("rst_seg", {1'b0, seg4}, 8'h7F);
        check("rst_dp",  {7'd0, dp4},  8'h01);

        a = 4'hA; b = 4'h3; op = 3'b010; mode = 1'b1; result = 4'hD; c_out = 1'b0; hold = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 36; k++) begin
            tick();
            check("seq_an4", an4, an_seq[(k / 4) % 8]);
            check("seq_an1", an1, an_seq[k % 8]);
            if (k == 0) check("first_seg", {1'b0, seg4}, {1'b0, 7'b1000000});
            else        check("seq_seg4",  {1'b0, seg4}, {1'b0, dig_tab[(k / 4) % 8]});
        end

        hold = 1'b1; result = 4'h5; c_out = 1'b1;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (an4 == 8'hFE) begin
                check("hold_seg0", {1'b0, seg4}, {1'b0, 7'b0100001});
                check("hold_dp0",  {7'd0, dp4},  8'h00);
            end else begin
                check("hold_dp", {7'd0, dp4}, 8'h01);
            end
            if (an4 == 8'hFD) check("hold_seg1", {1'b0, seg4}, {1'b0, 7'b1000000});
        end

        hold = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 32; k++) begin
            tick();
            if (an4 == 8'hFE) check("rel_seg0", {1'b0, seg4}, {1'b0, 7'b0010010});
            if (an4 == 8'hFD) check("rel_seg1", {1'b0, seg4}, {1'b0, 7'b1111001});
            check("rel_dp", {7'd0, dp4}, 8'h01);
        end

        found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            prev = an4;
            tick();
            if (prev == 8'hEF && an4 == 8'hFF) found = 1'b1;
        end
        check("find_idx5", {7'd0, found}, 8'h01);
        rst = 1'b1;
        tick();
        check("mid_rst_an",  an4,          8'hFF);
        check("mid_rst_seg", {1'b0, seg4}, 8'h7F);
        check("mid_rst_dp",  {7'd0, dp4},  8'h01);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("restart_an", an4, 8'hFE);
        end
        tick();
        check("restart_next", an4, 8'hFD);

        for (int k = 0; k < 3000; k++) begin
            a      = 4'($urandom_range(0, 15));
            b      = 4'($urandom_range(0, 15));
            op     = 3'($urandom_range(0, 7));
            mode   = 1'($urandom_range(0, 1));
            result = 4'($urandom_range(0, 15));
            c_out  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) hold = ~hold;
            rst    = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
